uart_rx_fifo: RTL and testbench

Oversampling UART receiver with line synchronizer, start-bit glitch rejection, optional parity check, stop-bit framing check and a small receive FIFO with a valid/ready output.
It sits on the serial input opposite the existing uart_tx and is the hardened replacement for the bare receiver.
Received bytes are buffered, so the consumer may stall without losing data until the FIFO fills.
Errors are reported as pulses plus a sticky overrun flag.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding, width helper.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Bit width needed to index n items; never returns 0.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pop_data always presents the head entry.
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = uart_pkg::safe_clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;

   // A push into a full FIFO is only taken when a pop frees the slot that cycle.
   assign do_pop_c  = pop && !empty;
   assign do_push_c = push && (!full || do_pop_c);

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push_c) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop_c) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push_c, do_pop_c})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with glitch-rejecting start detection, optional parity,
// stop-bit framing check and a show-ahead receive FIFO with valid/ready output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int unsigned CLKS_PER_BIT = 8,
   parameter  bit          PARITY_EN    = 1'b0,
   parameter  bit          PARITY_ODD   = 1'b0,
   parameter  int unsigned FIFO_DEPTH   = 4,
   localparam int unsigned COUNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   input  logic                 clr_err,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 rx_busy,
   output logic [COUNT_W-1:0]   fifo_count
);

   localparam int unsigned CNT_W = safe_clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = safe_clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                 rx_meta;
   logic                 rx_s;

   rx_state_t            state_q;
   rx_state_t            state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [BIT_W-1:0]     bit_q;
   logic [BIT_W-1:0]     bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 par_q;
   logic                 par_d;

   logic                 push_c;
   logic                 pop_c;
   logic                 frame_err_d;
   logic                 parity_err_d;
   logic                 overrun_d;
   logic                 fifo_empty;
   logic                 fifo_full;

   // Two-flop synchronizer, preset to the idle line level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= IDLE_LEVEL;
         rx_s    <= IDLE_LEVEL;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // FSM and datapath state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         frame_err  <= frame_err_d;
         parity_err <= parity_err_d;
         overrun    <= overrun_d;
         rx_busy    <= (state_d != IDLE);
      end
   end

   // Next-state logic; every sample after the start bit lands one bit period
   // after the previous one, so all are centred on the mid-bit point.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_d        = par_q;
      push_c       = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s != IDLE_LEVEL) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == MID_CNT) begin
               cnt_d = '0;
               if (rx_s == IDLE_LEVEL) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bit_d   = '0;
                  par_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == END_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_q == LAST_BIT) begin
                  state_d = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         PARITY: begin
            if (cnt_q == END_CNT) begin
               cnt_d   = '0;
               par_d   = (^shift_q) ^ rx_s ^ PARITY_ODD;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == END_CNT) begin
               cnt_d = '0;
               if (rx_s == IDLE_LEVEL) begin
                  push_c       = 1'b1;
                  parity_err_d = par_q;
                  state_d      = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s == IDLE_LEVEL) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sticky overrun: a dropped byte outranks a coincident clear.
   always_comb begin
      overrun_d = overrun;
      if (clr_err) begin
         overrun_d = 1'b0;
      end
      if (push_c && fifo_full && !pop_c) begin
         overrun_d = 1'b1;
      end
   end

   assign pop_c   = m_valid && m_ready;
   assign m_valid = !fifo_empty;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_c),
      .push_data (shift_q),
      .pop       (pop_c),
      .pop_data  (m_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: two receivers (no parity / even parity) driven by a serial frame
// generator, checked against a queue model of what each receiver must deliver.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx         [2];
   logic       m_ready    [2];
   logic       clr_err    [2];
   logic [7:0] m_data     [2];
   logic       m_valid    [2];
   logic       frame_err  [2];
   logic       parity_err [2];
   logic       overrun    [2];
   logic       rx_busy    [2];
   logic [2:0] fifo_count [2];

   int         tests;
   int         fails;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int         exp_fe [2];
   int         exp_pe [2];
   int         fe_cnt [2];
   int         pe_cnt [2];
   bit         exp_ovr [2];
   int         ready_mode [2];

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH)) dut0 (
      .clk(clk), .reset_n(reset_n), .rx(rx[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .clr_err(clr_err[0]), .frame_err(frame_err[0]),
      .parity_err(parity_err[0]), .overrun(overrun[0]), .rx_busy(rx_busy[0]),
      .fifo_count(fifo_count[0])
   );

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .reset_n(reset_n), .rx(rx[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .clr_err(clr_err[1]), .frame_err(frame_err[1]),
      .parity_err(parity_err[1]), .overrun(overrun[1]), .rx_busy(rx_busy[1]),
      .fifo_count(fifo_count[1])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] qpop(input int i);
      if (i == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   // Reference: a frame with a good stop bit yields its byte if the buffer has room,
   // otherwise the byte is lost and overrun latches; a bad stop bit yields only frame_err.
   function automatic void model_frame(input int i, input logic [7:0] b, input bit par_bad,
                                       input bit stop_ok);
      if (!stop_ok) begin
         exp_fe[i]++;
      end else begin
         if (i == 1 && par_bad) exp_pe[1]++;
         if (qsize(i) >= int'(DEPTH)) exp_ovr[i] = 1'b1;
         else if (i == 0) q0.push_back(b);
         else q1.push_back(b);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int i, input logic v);
      rx[i] = v;
      repeat (CPB) step();
   endtask

   task automatic send_frame(input int i, input logic [7:0] b, input bit par_bad,
                             input bit stop_ok, input int low_hold);
      drive_bit(i, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(i, b[k]);
      if (i == 1) drive_bit(i, (^b) ^ par_bad);
      model_frame(i, b, par_bad, stop_ok);
      drive_bit(i, stop_ok);
      if (!stop_ok) repeat (low_hold) step();
      rx[i] = 1'b1;
      repeat (2 * CPB) step();
   endtask

   task automatic wait_drain(input int i, input int budget);
      int n = 0;
      while (qsize(i) != 0 && n < budget) begin
         step();
         n++;
      end
      check($sformatf("drain_left%0d", i), 32'(qsize(i)), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_m_data%0d", tag, i), 32'(m_data[i]), 32'd0);
         check($sformatf("%s_m_valid%0d", tag, i), 32'(m_valid[i]), 32'd0);
         check($sformatf("%s_frame_err%0d", tag, i), 32'(frame_err[i]), 32'd0);
         check($sformatf("%s_parity_err%0d", tag, i), 32'(parity_err[i]), 32'd0);
         check($sformatf("%s_overrun%0d", tag, i), 32'(overrun[i]), 32'd0);
         check($sformatf("%s_rx_busy%0d", tag, i), 32'(rx_busy[i]), 32'd0);
         check($sformatf("%s_count%0d", tag, i), 32'(fifo_count[i]), 32'd0);
      end
   endtask

   task automatic check_err_counts(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_frame_errs%0d", tag, i), 32'(fe_cnt[i]), 32'(exp_fe[i]));
         check($sformatf("%s_parity_errs%0d", tag, i), 32'(pe_cnt[i]), 32'(exp_pe[i]));
      end
   endtask

   // Consumer: m_ready per receiver is held low, held high or randomised each cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            m_ready[i] = (ready_mode[i] == 0) ? 1'b0 :
                         (ready_mode[i] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: pops the scoreboard on each handshake, counts error pulses,
   // and checks the head stays put while stalled.
   initial begin
      bit         pv [2];
      bit         pr [2];
      logic [7:0] pd [2];
      pv = '{1'b0, 1'b0};
      pr = '{1'b0, 1'b0};
      pd = '{8'h00, 8'h00};
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (frame_err[i] === 1'b1) fe_cnt[i]++;
            if (parity_err[i] === 1'b1) pe_cnt[i]++;
            if (reset_n && pv[i] && !pr[i]) begin
               check($sformatf("hold_valid%0d", i), 32'(m_valid[i]), 32'd1);
               check($sformatf("hold_data%0d", i), 32'(m_data[i]), 32'(pd[i]));
            end
            if (m_valid[i] === 1'b1 && m_ready[i] === 1'b1) begin
               if (qsize(i) == 0) begin
                  check($sformatf("unexpected_byte%0d", i), 32'(m_data[i]), 32'hFFFF_FFFF);
               end else begin
                  check($sformatf("rx_byte%0d", i), 32'(m_data[i]), 32'(qpop(i)));
               end
            end
            pv[i] = reset_n && (m_valid[i] === 1'b1);
            pr[i] = (m_ready[i] === 1'b1);
            pd[i] = m_data[i];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int         busy;
      int         inst;
      logic [7:0] b;
      tests = 0;
      fails = 0;
      exp_fe = '{0, 0};
      exp_pe = '{0, 0};
      fe_cnt = '{0, 0};
      pe_cnt = '{0, 0};
      exp_ovr = '{1'b0, 1'b0};
      ready_mode = '{1, 1};
      rx = '{1'b1, 1'b1};
      clr_err = '{1'b0, 1'b0};
      reset_n = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (4) step();

      // Single clean frame.
      send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
      wait_drain(0, 200);
      check("a5_count", 32'(fifo_count[0]), 32'd0);
      check("a5_busy", 32'(rx_busy[0]), 32'd0);
      check_err_counts("a5");

      // Short low glitch on the line.
      rx[0] = 1'b0;
      repeat (2) step();
      rx[0] = 1'b1;
      busy = 0;
      repeat (24) begin
         if (rx_busy[0] === 1'b1) busy++;
         step();
      end
      check("glitch_busy_seen", 32'(busy > 0), 32'd1);
      check("glitch_busy_len", 32'(busy <= int'(CPB / 2 + 2)), 32'd1);
      check("glitch_count", 32'(fifo_count[0]), 32'd0);
      check_err_counts("glitch");

      // Framing error followed by a long break, then a good frame.
      send_frame(0, 8'h3C, 1'b0, 1'b0, 40);
      send_frame(0, 8'h81, 1'b0, 1'b1, 0);
      wait_drain(0, 200);
      check_err_counts("frame");

      // Even parity: wrong parity bit, then correct parity bit.
      send_frame(1, 8'h5A, 1'b1, 1'b1, 0);
      wait_drain(1, 200);
      check("par_bad_errs", 32'(pe_cnt[1]), 32'(exp_pe[1]));
      send_frame(1, 8'h5A, 1'b0, 1'b1, 0);
      wait_drain(1, 200);
      check_err_counts("parity");

      // Overrun with a stalled consumer.
      ready_mode[0] = 0;
      step();
      for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b1, 0);
      repeat (4) step();
      check("ovr_count", 32'(fifo_count[0]), 32'(DEPTH));
      check("ovr_flag", 32'(overrun[0]), 32'(exp_ovr[0]));
      check("ovr_valid", 32'(m_valid[0]), 32'd1);
      check("ovr_head", 32'(m_data[0]), 32'h01);
      ready_mode[0] = 1;
      wait_drain(0, 200);
      check("ovr_sticky", 32'(overrun[0]), 32'd1);
      clr_err[0] = 1'b1;
      step();
      clr_err[0] = 1'b0;
      exp_ovr[0] = 1'b0;
      step();
      check("ovr_cleared", 32'(overrun[0]), 32'(exp_ovr[0]));

      // Reset in the middle of data bit 4, then a clean frame.
      drive_bit(0, 1'b0);
      for (int k = 0; k < 4; k++) drive_bit(0, 1'(k & 1));
      rx[0] = 1'b1;
      repeat (3) step();
      reset_n = 1'b0;
      repeat (2) step();
      check_reset_outputs("midreset");
      reset_n = 1'b1;
      repeat (3 * CPB) step();
      send_frame(0, 8'h7E, 1'b0, 1'b1, 0);
      wait_drain(0, 200);
      check_err_counts("postreset");

      // Random frames, random back-pressure, occasional parity and framing faults.
      ready_mode = '{2, 2};
      for (int n = 0; n < 16; n++) begin
         inst = int'($urandom_range(0, 1));
         b = 8'($urandom);
         send_frame(inst, b, (inst == 1) && ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 5) != 0, int'($urandom_range(0, 30)));
      end
      wait_drain(0, 400);
      wait_drain(1, 400);
      check_err_counts("random");
      for (int i = 0; i < 2; i++) begin
         check($sformatf("final_overrun%0d", i), 32'(overrun[i]), 32'(exp_ovr[i]));
         check($sformatf("final_count%0d", i), 32'(fifo_count[i]), 32'd0);
         check($sformatf("final_busy%0d", i), 32'(rx_busy[i]), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
